// File: rtl/if_fetch_pkg.sv
// Shared constants and types for the RV32 instruction-fetch stage.
package if_fetch_pkg;

  typedef logic [31:0] inst_addr_t;
  typedef logic [31:0] inst_t;

  localparam inst_t      ZeroWord     = 32'h0000_0000;
  localparam inst_addr_t PcStep       = 32'h0000_0004;
  localparam int         IfQueueDepth = 2;
  localparam logic       ChipEnable   = 1'b1;
  localparam logic       ChipDisable  = 1'b0;

  localparam logic [0:0] IfBoot = 1'b0;
  localparam logic [0:0] IfRun  = 1'b1;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } if_entry_t;

  // Redirect targets may carry stray low bits; instructions are word aligned.
  function automatic inst_addr_t align_word(input inst_addr_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_queue.sv
// Two-entry synchronous FIFO of {pc, inst} pairs between fetch and decode.
module if_queue
  import if_fetch_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  logic      clear,
  input  if_entry_t push_data,
  output logic      full,
  output logic      empty,
  output if_entry_t head
);

  if_entry_t  mem [IfQueueDepth];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;

  // Clear wins over a simultaneous pop: a flushed queue is empty regardless.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign full  = (count == 2'(IfQueueDepth));
  assign empty = (count == 2'd0);
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, drives the ROM and feeds decode through a
// two-entry queue, flushing it on execute redirects.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter inst_addr_t RESET_PC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst,
  output logic       rom_ce_o,
  output inst_addr_t rom_addr_o,
  input  inst_t      rom_inst_i,
  input  logic       branch_flag_i,
  input  inst_addr_t branch_target_i,
  output logic       if_valid_o,
  input  logic       if_ready_i,
  output inst_addr_t if_pc_o,
  output inst_t      if_inst_o
);

  // Decode handshake: if_valid_o/if_pc_o/if_inst_o never depend on
  // if_ready_i; the head is consumed on any edge where valid && ready.

  logic [0:0] state;
  logic       rst_q;
  inst_addr_t pc;
  logic       fetch;
  logic       pop;
  logic       full;
  logic       empty;
  if_entry_t  head;
  if_entry_t  push_data;

  assign fetch     = (state == IfRun) && !full && !branch_flag_i;
  assign pop       = !empty && if_ready_i;
  assign push_data = '{pc: pc, inst: rom_inst_i};

  // rst_q delays the BOOT->RUN step so BOOT spans one full cycle with rst high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IfBoot;
      rst_q <= 1'b0;
    end else begin
      rst_q <= 1'b1;
      if (state == IfBoot && rst_q) state <= IfRun;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (branch_flag_i) begin
      pc <= align_word(branch_target_i);
    end else if (fetch) begin
      pc <= pc + PcStep;
    end
  end

  if_queue u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (fetch),
    .pop       (pop),
    .clear     (branch_flag_i),
    .push_data (push_data),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  assign rom_ce_o   = fetch ? ChipEnable : ChipDisable;
  assign rom_addr_o = pc;
  assign if_valid_o = !empty;
  assign if_pc_o    = empty ? 32'h0000_0000 : head.pc;
  assign if_inst_o  = empty ? ZeroWord : head.inst;

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the RV32 core. Owns the program counter, drives the instruction ROM's chip-enable and word address, and captures each returned word with its PC into a 2-entry queue. Decode drains the queue through a valid/ready handshake. The block accepts branch/jump redirects from execute and discards everything fetched down the wrong path.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; must be 4-byte aligned.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-low (0 = reset).
- `rom_ce_o`  out  1  ROM chip enable (`ChipEnable`/`ChipDisable`).
- `rom_addr_o`  out  `InstAddrBus`  byte address to the ROM; always the current PC.
- `rom_inst_i`  in  `InstBus`  ROM data, combinational from `rom_addr_o`, already in instruction byte order.
- `branch_flag_i`  in  1  redirect request from execute, held for one cycle.
- `branch_target_i`  in  `InstAddrBus`  redirect address; bits [1:0] are ignored and treated as 0.
- `if_valid_o`  out  1  queue head holds a valid instruction.
- `if_ready_i`  in  1  decode accepts the head this cycle.
- `if_pc_o`  out  `InstAddrBus`  PC of the head entry.
- `if_inst_o`  out  `InstBus`  instruction of the head entry; `ZeroWord` when empty.

## Operation
- FSM has two states.
  - BOOT: entered on reset and held for exactly one cycle after `rst` returns to 1. `rom_ce_o`=0.
  - RUN: normal fetch. Entered from BOOT unconditionally and never left except through reset.
- Fetch (push) condition is `fetch = (state==RUN) && (count<2) && !branch_flag_i`.
  - `rom_ce_o` equals `fetch`.
  - `rom_ce_o` has no combinational dependence on `if_ready_i`.
- On a fetch cycle:
  - {pc, `rom_inst_i`} is written to the queue tail.
  - pc <= pc + 4, wrapping modulo 2^32.
- Pop condition is `pop = if_valid_o && if_ready_i`. A pop removes the head.
- Count update: count <= count + fetch − pop, range 0..2.
  - `if_valid_o` = (count != 0).
  - Head and tail pointers are 1 bit each and wrap.
- Redirect (`branch_flag_i`=1 in RUN or BOOT):
  - Next edge: count <= 0, both pointers <= 0, pc <= {target[31:2],2'b00}.
  - No push in that cycle.
  - A pop in the same cycle still counts as a completed handshake; decode is responsible for flushing that instruction.
- Full (count==2): fetch stops, `rom_ce_o`=0, pc holds.
- Pop and push in the same cycle at count==1: count stays 1, giving a sustained 1 instruction per cycle.
- Reset (`rst`=0 at an edge), including mid-stream or mid-redirect:
  - pc <= `RESET_PC`, count <= 0, pointers <= 0, state <= BOOT.
  - Reset overrides redirect.

## Timing
- Reset values of all outputs:
  - `rom_ce_o`=0
  - `rom_addr_o`=`RESET_PC`
  - `if_valid_o`=0
  - `if_pc_o`=0
  - `if_inst_o`=`ZeroWord`
- Startup sequence, with reset released before edge E0:
  - cycle after E0: BOOT, ce=0.
  - after E1: ce=1, addr=`RESET_PC`.
  - after E2: `if_valid_o`=1, `if_pc_o`=`RESET_PC`.
- Fetch-to-valid latency: 1 cycle.
- Redirect latency: `branch_flag_i` in cycle t, then ce=1 with addr=target in cycle t+1, then head=target in cycle t+2. Entries that were valid in cycle t are gone in cycle t+1.
- Outputs to decode come from queue registers only; there is no combinational path from `rom_inst_i` to `if_*_o`.

## Structure
- Add to shared `defines.v`:
  - `PcStep` (32'h4)
  - `IfQueueDepth` (2)
  - `IfBoot`/`IfRun` state encodings
- Reuse the existing `InstAddrBus`, `InstBus`, `ZeroWord`, `ChipEnable`, and `ChipDisable`.
- One sub-module, `if_queue`: 2-entry synchronous FIFO of {pc, inst}.
  - Ports: push, pop, clear, full, empty, head data.
- The PC register, FSM, and redirect logic live in `if_fetch`.

## Test plan
- Reset then free-run with `if_ready_i`=1 and `RESET_PC`=0 → `rom_ce_o` low for exactly 1 cycle after reset; decode then receives PCs 0,4,8,12 one per cycle with the matching ROM words.
- `if_ready_i`=0 for 5 cycles → count saturates at 2 and `rom_ce_o`=0. Raising ready → PCs 0 and 4 delivered, then 8, with no duplicates or gaps.
- `branch_flag_i` with target 32'h40 while count==2 → queue empty the next cycle; in cycle t+2 the head is pc=32'h40; old PCs are never presented again.
- Target 32'h43 → fetch resumes at 32'h40.
- Start at pc=32'hFFFF_FFFC → next fetch address is 32'h0000_0000.
- Drive `rst`=0 for one edge mid-stream, with a simultaneous redirect → all outputs at their reset values, followed by the normal BOOT/RUN startup sequence.
